// File: rtl/multichannel_window_framer.sv
// multichannel_window_framer
//   N-channel ping-pong frame buffer feeding a windowing multiplier.
//   The writer fills one bank with ADC samples while the reader streams the
//   other bank out, multiplied by a per-index window coefficient.
//
// Build option:
//   MCWF_COEF_RAM_EN defined   : two-page host-writable coefficient RAM,
//                                page chosen by win_sel latched per frame.
//   MCWF_COEF_RAM_EN undefined : unity window (output = sign-extended sample),
//                                win_sel and coef_* ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               arm acquisition, clear overrun state, restart write frame
//   in_data/in_valid    NCH samples of DW bits, channel k at [k*DW +: DW]
//   win_sel             coefficient page for the next frame to be read
//   coef_we/page/addr/wdata  coefficient RAM write port
//   out_data/out_valid/out_last/out_ready  windowed stream, channel k at [k*OW +: OW]
//   busy                reader active
//   overrun/overrun_cnt sticky drop flag and saturating dropped-frame count
module multichannel_window_framer #(
  parameter int NCH        = 2,
  parameter int DW         = 16,
  parameter int CW         = 18,
  parameter int FRAME_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NCH*DW-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      win_sel,
  input  logic                      coef_we,
  input  logic                      coef_page,
  input  logic [FRAME_LOG2-1:0]     coef_addr,
  input  logic [CW-1:0]             coef_wdata,
  output logic [NCH*(DW+2)-1:0]     out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun,
  output logic [15:0]               overrun_cnt
);

  localparam int OW   = DW + 2;
  localparam int PW   = DW + CW;
  localparam int FLEN = 1 << FRAME_LOG2;
  localparam logic [FRAME_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} rd_state_t;

  // writer state
  logic                  r_armed;
  logic [1:0]            r_full;
  logic [1:0]            w_full_nxt;
  logic                  r_wr_bank;
  logic [FRAME_LOG2-1:0] r_wr_idx;
  logic                  r_drop;
  logic                  r_overrun;
  logic [15:0]           r_overrun_cnt;

  // reader state
  rd_state_t             r_state, w_state_nxt;
  logic                  r_rd_bank;
  logic [FRAME_LOG2-1:0] r_rd_idx;

  // pipeline
  logic                     w_pipe_en, w_issue, w_rd_done;
  logic                     r_s1_valid, r_s1_last;
  logic [NCH*DW-1:0]        r_s1_samp;
  logic signed [CW-1:0]     w_s1_coef;
  logic                     r_s2_valid, r_s2_last;
  logic signed [PW-1:0]     r_s2_prod [NCH];
  logic                     r_out_valid, r_out_last;
  logic [NCH*OW-1:0]        r_out_data;

  logic                     w_accept, w_wr_last, w_tgt, w_tgt_free, w_mem_we;

  logic [NCH*DW-1:0]        r_smem [2*FLEN];

  assign w_pipe_en = out_ready | ~r_out_valid;
  assign w_issue   = (r_state == ST_RUN) & w_pipe_en;
  assign w_rd_done = w_issue & (r_rd_idx == LAST_IDX);

  // ---------------------------------------------------------------- writer
  assign w_accept  = in_valid & r_armed & ~start;
  assign w_wr_last = w_accept & (r_wr_idx == LAST_IDX);
  assign w_tgt     = ~r_wr_bank;
  // a bank being released by the reader this very cycle counts as free
  assign w_tgt_free = ~r_full[w_tgt] | (w_rd_done & (r_rd_bank == w_tgt));
  assign w_mem_we  = w_accept & ~r_drop;

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_done)
      w_full_nxt[r_rd_bank] = 1'b0;
    if (w_mem_we && w_wr_last)
      w_full_nxt[r_wr_bank] = 1'b1;
  end

  // While dropping, r_wr_bank still points at the last bank filled; the
  // target stays ~r_wr_bank, so the end-of-frame test is shared by both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed       <= 1'b0;
      r_full        <= '0;
      r_wr_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_drop        <= 1'b0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (start) begin
        r_armed       <= 1'b1;
        r_overrun     <= 1'b0;
        r_overrun_cnt <= '0;
        r_wr_idx      <= '0;
        // a pending drop ends early only if the next bank is already free
        if (r_drop && w_tgt_free) begin
          r_drop    <= 1'b0;
          r_wr_bank <= w_tgt;
        end
      end else if (w_accept) begin
        r_wr_idx <= r_wr_idx + 1'b1;
        if (w_wr_last) begin
          if (r_drop) begin
            r_overrun <= 1'b1;
            if (r_overrun_cnt != 16'hFFFF)
              r_overrun_cnt <= r_overrun_cnt + 16'd1;
          end
          if (w_tgt_free) begin
            r_wr_bank <= w_tgt;
            r_drop    <= 1'b0;
          end else begin
            r_drop <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_smem[{r_wr_bank, r_wr_idx}] <= in_data;
  end

  // ---------------------------------------------------------------- reader FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_full[r_rd_bank]) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_rd_done)         w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue)
        r_rd_idx <= r_rd_idx + 1'b1;
      if (w_rd_done)
        r_rd_bank <= ~r_rd_bank;
    end
  end

  // ---------------------------------------------------------------- coefficients
`ifdef MCWF_COEF_RAM_EN
  logic signed [CW-1:0] r_cmem [2*FLEN];
  logic signed [CW-1:0] r_s1_coef;
  logic                 r_page;

  always_ff @(posedge clk) begin
    if (coef_we)
      r_cmem[{coef_page, coef_addr}] <= coef_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page    <= 1'b0;
      r_s1_coef <= '0;
    end else begin
      if (r_state == ST_IDLE && r_full[r_rd_bank])
        r_page <= win_sel;
      if (w_pipe_en)
        r_s1_coef <= r_cmem[{r_page, r_rd_idx}];
    end
  end

  assign w_s1_coef = r_s1_coef;
`else
  localparam logic signed [CW-1:0] C_UNITY = {2'b01, {(CW-2){1'b0}}};
  logic w_unused_cfg;

  assign w_s1_coef    = C_UNITY;
  assign w_unused_cfg = ^{win_sel, coef_we, coef_page, coef_addr, coef_wdata};
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_samp   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++)
        r_s2_prod[k] <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pipe_en) begin
      r_s1_valid  <= w_issue;
      r_s1_last   <= w_rd_done;
      r_s1_samp   <= r_smem[{r_rd_bank, r_rd_idx}];
      r_s2_valid  <= r_s1_valid;
      r_s2_last   <= r_s1_last;
      for (int unsigned k = 0; k < NCH; k++)
        r_s2_prod[k] <= $signed(r_s1_samp[k*DW +: DW]) * w_s1_coef;
      r_out_valid <= r_s2_valid;
      r_out_last  <= r_s2_last;
      // arithmetic shift floors toward -inf, then keep the low OW bits
      for (int unsigned k = 0; k < NCH; k++)
        r_out_data[k*OW +: OW] <= OW'(r_s2_prod[k] >>> (CW-2));
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign busy        = (r_state == ST_RUN);
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;

endmodule
